lane_packer: RTL and testbench

LANE_PACKER -- requirements
Module: lane_packer

---
 rtl/lane_packer_if.sv | 38 +++
 rtl/lane_packer.sv | 106 ++++++++++
 tb/tb_lane_packer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lane_packer_if.sv
// Nibble-in / byte-out handshake bundle for lane_packer.
// Producer side drives nibbles and pop; packer side returns FIFO status.
interface lane_packer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          sync_clear;
  logic          in_valid;
  logic [0:3]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output sync_clear,
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  count,
    input  overflow
  );

  modport slave (
    input  sync_clear,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output count,
    output overflow
  );
endinterface

// File: rtl/lane_packer.sv
// Packs pairs of lane nibbles into bytes and buffers them in a
// small FIFO with a sticky overflow flag on dropped bytes.
module lane_packer #(
  parameter int DEPTH = 4
) (
  input logic        clock,
  input logic        reset,
  lane_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    LOW_EMPTY = 1'b0,
    HAVE_HIGH = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    hi;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          load_hi;
  logic          push;
  logic          pop;
  logic          write;
  logic          drop;
  logic [7:0]    packed_byte;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOW_EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.sync_clear)
      state_nx = LOW_EMPTY;
    else if (bus.in_valid)
      state_nx = (state == LOW_EMPTY) ? HAVE_HIGH : LOW_EMPTY;
  end

  always_comb begin
    load_hi = 1'b0;
    push    = 1'b0;
    unique case (1'b1)
      (state == LOW_EMPTY):
        load_hi = bus.in_valid & ~bus.sync_clear;
      (state == HAVE_HIGH):
        push = bus.in_valid & ~bus.sync_clear;
      default: ;
    endcase
  end

  assign packed_byte = {hi, bus.in_data};
  assign pop   = (cnt != '0) & bus.out_ready & ~bus.sync_clear;
  // A pop on a full FIFO frees the very slot the push lands in
  assign write = push & ((cnt != FULL) | pop);
  assign drop  = push & (cnt == FULL) & ~pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        hi <= '0;
    else if (load_hi) hi <= bus.in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write) begin
      mem[wr_ptr] <= packed_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (bus.sync_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({write, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  assign bus.out_valid = (cnt != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_lane_packer.sv
// Self-checking bench for lane_packer: constant vector table,
// directed corner sequences and a queue-based reference model.
module tb_lane_packer;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   npop   = 0;

  lane_packer_if #(.DEPTH(DEPTH)) bus();

  lane_packer #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Reference model: byte queue plus pending high nibble
  logic [7:0] q[$];
  bit         have_hi;
  logic [3:0] hi_m;
  bit         ovf_m;

  typedef struct {
    logic       sc;
    logic       iv;
    logic [3:0] d;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    int         ec;
    logic       eo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic sc, input logic iv,
                     input logic [3:0] d, input logic rdy,
                     input logic ev, input logic [7:0] ed,
                     input int ec, input logic eo);
    vec_t v;
    v.sc = sc; v.iv = iv; v.d = d; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    have_hi = 0;
    hi_m    = '0;
    ovf_m   = 0;
  endtask

  task automatic model_edge(input logic sc, input logic iv,
                            input logic [3:0] d, input logic rdy);
    logic [7:0] b;
    bit popped;
    if (sc) begin
      model_reset();
      return;
    end
    popped = (q.size() != 0) && rdy;
    if (popped) void'(q.pop_front());
    if (iv) begin
      if (have_hi) begin
        b = {hi_m, d};
        if (q.size() < DEPTH) q.push_back(b);
        else ovf_m = 1;
        have_hi = 0;
      end else begin
        hi_m    = d;
        have_hi = 1;
      end
    end
  endtask

  task automatic step(input logic sc, input logic iv,
                      input logic [3:0] d, input logic rdy);
    bus.sync_clear = sc;
    bus.in_valid   = iv;
    bus.in_data    = d;
    bus.out_ready  = rdy;
    if (bus.out_valid && rdy && !sc) npop++;
    @(posedge clock);
    model_edge(sc, iv, d, rdy);
    @(negedge clock);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(ovf_m));
    if (q.size() != 0)
      chk({tag, ".data"}, 32'(bus.out_data), 32'(q[0]));
  endtask

  initial begin
    int k;
    bit rdy_t;
    reset          = 1'b1;
    bus.sync_clear = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    model_reset();

    #12;
    chk("rst.valid", 32'(bus.out_valid), 0);
    chk("rst.count", 32'(bus.count), 0);
    chk("rst.ovf", 32'(bus.overflow), 0);
    chk("rst.data", 32'(bus.out_data), 32'h00);
    @(negedge clock);
    reset = 1'b0;

    // Basic pack
    add(0, 1, 4'hA, 1, 0, 8'h00, 0, 0);
    add(0, 1, 4'h3, 1, 1, 8'hA3, 1, 0);
    add(0, 0, 4'h0, 1, 0, 8'h00, 0, 0);
    // Fill and overflow with the consumer stalled
    for (int n = 1; n <= 10; n++) begin
      k = (n / 2 > DEPTH) ? DEPTH : n / 2;
      add(0, 1, 4'(n), 0, k != 0, 8'h12, k, n == 10);
    end
    add(0, 0, 4'h0, 1, 1, 8'h34, 3, 1);
    add(0, 0, 4'h0, 1, 1, 8'h56, 2, 1);
    add(0, 0, 4'h0, 1, 1, 8'h78, 1, 1);
    add(0, 0, 4'h0, 1, 0, 8'h00, 0, 1);
    add(0, 0, 4'h0, 1, 0, 8'h00, 0, 1);
    add(1, 1, 4'h5, 1, 0, 8'h00, 0, 0);
    // Odd nibble then sync_clear swallowing a nibble
    add(0, 1, 4'hF, 0, 0, 8'h00, 0, 0);
    add(1, 1, 4'h1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 4'h2, 0, 0, 8'h00, 0, 0);
    add(0, 1, 4'h3, 0, 1, 8'h23, 1, 0);
    add(0, 0, 4'h0, 1, 0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].sc, tbl[i].iv, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl[%0d].valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl[%0d].count", i), 32'(bus.count), 32'(tbl[i].ec));
      chk($sformatf("tbl[%0d].ovf", i), 32'(bus.overflow), 32'(tbl[i].eo));
      if (tbl[i].ev)
        chk($sformatf("tbl[%0d].data", i), 32'(bus.out_data), 32'(tbl[i].ed));
    end

    // Full FIFO with simultaneous push and pop
    for (int n = 1; n <= 4; n++) begin
      step(0, 1, 4'(n), 0);
      step(0, 1, 4'(n), 0);
    end
    chk("full.count", 32'(bus.count), 4);
    step(0, 1, 4'h5, 0);
    step(0, 1, 4'h5, 1);
    chk("pp.count", 32'(bus.count), 4);
    chk("pp.ovf", 32'(bus.overflow), 0);
    chk("pp.head", 32'(bus.out_data), 32'h22);
    step(0, 0, 4'h0, 1);
    chk("pp.d33", 32'(bus.out_data), 32'h33);
    step(0, 0, 4'h0, 1);
    chk("pp.d44", 32'(bus.out_data), 32'h44);
    step(0, 0, 4'h0, 1);
    chk("pp.d55", 32'(bus.out_data), 32'h55);
    step(0, 0, 4'h0, 1);
    chk("pp.empty", 32'(bus.count), 0);

    // Async reset mid-stream: overflow set, count 2, nibble held
    for (int n = 1; n <= 10; n++) step(0, 1, 4'(n), 0);
    step(0, 0, 4'h0, 1);
    step(0, 0, 4'h0, 1);
    step(0, 1, 4'h7, 0);
    chk_model("pre_rst");
    chk("pre_rst.count", 32'(bus.count), 2);
    #2 reset = 1'b1;
    #1;
    chk("arst.valid", 32'(bus.out_valid), 0);
    chk("arst.count", 32'(bus.count), 0);
    chk("arst.ovf", 32'(bus.overflow), 0);
    chk("arst.data", 32'(bus.out_data), 32'h00);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(0, 1, 4'h5, 0);
    chk("arst.held", 32'(bus.count), 0);
    step(0, 1, 4'h6, 0);
    chk("arst.d56", 32'(bus.out_data), 32'h56);
    chk("arst.cnt1", 32'(bus.count), 1);
    step(0, 0, 4'h0, 1);

    // Empty pop, then streaming with toggling ready
    step(0, 0, 4'h0, 1);
    chk_model("epop");
    chk("epop.count", 32'(bus.count), 0);
    npop = 0;
    for (int i = 0; i < 6 * DEPTH; i++) begin
      step(0, 1, 4'($urandom_range(0, 15)), 1'(i % 2));
      chk_model($sformatf("strm%0d", i));
    end
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) begin
      step(0, 0, 4'h0, 1);
      chk_model($sformatf("drain%0d", i));
    end
    chk("strm.popped", 32'(npop), 32'(3 * DEPTH));
    chk("strm.ovf", 32'(bus.overflow), 0);

    // Randomised traffic against the model
    rdy_t = 0;
    for (int i = 0; i < 600; i++) begin
      rdy_t = ($urandom_range(0, 3) == 0) ? ~rdy_t : rdy_t;
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7),
           4'($urandom_range(0, 15)),
           rdy_t);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
